// File: rtl/risc_core_pkg.sv
// Shared constants, FSM state type and immediate helper for risc_core.
// RISC_CORE_SUB_EN adds the SUB funct7 constant.
package risc_core_pkg;

    localparam int unsigned WORD_SIZE_B_DEF = 4;

    localparam logic [6:0] OPC_LW = 7'b0000011;
    localparam logic [6:0] OPC_SW = 7'b0100011;
    localparam logic [6:0] OPC_OP = 7'b0110011;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [6:0] F7_ADD  = 7'b0000000;
`ifdef RISC_CORE_SUB_EN
    localparam logic [6:0] F7_SUB  = 7'b0100000;
`endif

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_t;

    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/risc_core_regfile.sv
// 32-entry register file: two async read ports, one write port, x0 hardwired to 0.
module risc_core_regfile #(
    parameter int unsigned DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [4:0]    i_raddr1,
    output logic [DW-1:0] o_rdata1,
    input  logic [4:0]    i_raddr2,
    output logic [DW-1:0] o_rdata2,
    input  logic          i_we,
    input  logic [4:0]    i_waddr,
    input  logic [DW-1:0] i_wdata
);

    logic [DW-1:0] r_regs [32];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/risc_core.sv
// Multi-cycle LW/SW/ADD core on one word-addressed request/acknowledge memory port.
// Define RISC_CORE_SUB_EN to execute SUB (funct7 0100000); otherwise it is a NOP.
module risc_core
    import risc_core_pkg::*;
#(
    parameter int unsigned RAM_CAPACITY = 1024,
    parameter int unsigned WORD_SIZE_B  = WORD_SIZE_B_DEF
) (
    input  logic                            Clk,
    input  logic                            Rst,
    output logic [$clog2(RAM_CAPACITY)-1:0] Addr,
    output logic                            Cs,
    output logic                            We,
    output logic [8*WORD_SIZE_B-1:0]        Wdata,
    input  logic [8*WORD_SIZE_B-1:0]        Rdata,
    input  logic                            Ack
);

    localparam int unsigned AW = $clog2(RAM_CAPACITY);
    localparam int unsigned DW = 8 * WORD_SIZE_B;

    state_t          r_state;
    state_t          w_next_state;
    logic [AW-1:0]   r_pc;
    logic [31:0]     r_ir;
    logic [DW-1:0]   r_ldata;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic            w_is_lw;
    logic            w_is_sw;
    logic            w_is_add;
    logic            w_is_sub;
    logic [11:0]     w_imm;
    logic [AW-1:0]   w_ea;
    logic [DW-1:0]   w_rs1;
    logic [DW-1:0]   w_rs2;
    logic [DW-1:0]   w_alu;

    logic            w_cs;
    logic            w_we;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;
    logic            w_ir_load;
    logic            w_ld_load;
    logic            w_pc_inc;
    logic            w_rf_we;
    logic [DW-1:0]   w_rf_wdata;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];
    assign w_funct7 = r_ir[31:25];

    assign w_is_lw  = (w_opcode == OPC_LW) && (w_funct3 == F3_WORD);
    assign w_is_sw  = (w_opcode == OPC_SW) && (w_funct3 == F3_WORD);
    assign w_is_add = (w_opcode == OPC_OP) && (w_funct3 == F3_ADD) && (w_funct7 == F7_ADD);
`ifdef RISC_CORE_SUB_EN
    assign w_is_sub = (w_opcode == OPC_OP) && (w_funct3 == F3_ADD) && (w_funct7 == F7_SUB);
`else
    assign w_is_sub = 1'b0;
`endif

    assign w_imm = w_is_sw ? {r_ir[31:25], r_ir[11:7]} : r_ir[31:20];
    assign w_ea  = AW'(w_rs1 + DW'(sext12(w_imm)));

    always_comb begin
        w_alu = w_rs1 + w_rs2;
`ifdef RISC_CORE_SUB_EN
        if (w_is_sub) begin
            w_alu = w_rs1 - w_rs2;
        end
`endif
    end

    risc_core_regfile #(
        .DW(DW)
    ) u_regfile (
        .i_clk    (Clk),
        .i_rst_n  (Rst),
        .i_raddr1 (r_ir[19:15]),
        .o_rdata1 (w_rs1),
        .i_raddr2 (r_ir[24:20]),
        .o_rdata2 (w_rs2),
        .i_we     (w_rf_we),
        .i_waddr  (r_ir[11:7]),
        .i_wdata  (w_rf_wdata)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cs         = 1'b0;
        w_we         = 1'b0;
        w_addr       = r_pc;
        w_wdata      = '0;
        w_ir_load    = 1'b0;
        w_ld_load    = 1'b0;
        w_pc_inc     = 1'b0;
        w_rf_we      = 1'b0;
        w_rf_wdata   = '0;
        case (r_state)
            ST_FETCH: begin
                w_cs = 1'b1;
                if (Ack) begin
                    w_ir_load    = 1'b1;
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_is_add || w_is_sub) begin
                    w_rf_we      = 1'b1;
                    w_rf_wdata   = w_alu;
                    w_pc_inc     = 1'b1;
                    w_next_state = ST_FETCH;
                end else if (w_is_lw || w_is_sw) begin
                    w_next_state = ST_MEM;
                end else begin
                    w_pc_inc     = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            ST_MEM: begin
                w_cs   = 1'b1;
                w_addr = w_ea;
                if (w_is_sw) begin
                    w_we    = 1'b1;
                    w_wdata = w_rs2;
                end
                if (Ack) begin
                    if (w_is_lw) begin
                        w_ld_load    = 1'b1;
                        w_next_state = ST_WB;
                    end else begin
                        w_pc_inc     = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                w_rf_we      = 1'b1;
                w_rf_wdata   = r_ldata;
                w_pc_inc     = 1'b1;
                w_next_state = ST_FETCH;
            end
            default: w_next_state = ST_FETCH;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_pc    <= '0;
            r_ir    <= '0;
            r_ldata <= '0;
        end else begin
            if (w_ir_load) begin
                r_ir <= 32'(Rdata);
            end
            if (w_ld_load) begin
                r_ldata <= Rdata;
            end
            if (w_pc_inc) begin
                r_pc <= r_pc + AW'(1);
            end
        end
    end

    // Reset state is FETCH, so the request is masked by Rst to keep Cs low during reset.
    assign Cs    = w_cs & Rst;
    assign We    = w_we;
    assign Addr  = w_addr;
    assign Wdata = w_wdata;

endmodule

// File: tb/tb_risc_core.sv
// Self-checking bench for risc_core: directed vector table, reset abort sequence,
// and random programs checked against an instruction-level reference model.
module tb_risc_core;

    localparam int unsigned RAM = 1024;
    localparam int unsigned AW  = 10;
`ifdef RISC_CORE_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic [AW-1:0] Addr;
    logic          Cs;
    logic          We;
    logic [31:0]   Wdata;
    logic [31:0]   Rdata = '0;
    logic          Ack = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 Clk = ~Clk;

    risc_core #(
        .RAM_CAPACITY(RAM),
        .WORD_SIZE_B (4)
    ) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Addr  (Addr),
        .Cs    (Cs),
        .We    (We),
        .Wdata (Wdata),
        .Rdata (Rdata),
        .Ack   (Ack)
    );

    typedef struct {
        logic [31:0]   instr;
        int unsigned   fwait;
        int unsigned   dwait;
        logic [31:0]   ldata;
        bit            has_data;
        logic          exp_we;
        logic [AW-1:0] exp_daddr;
        logic [31:0]   exp_wdata;
        logic [AW-1:0] exp_pc;
        int unsigned   exp_fgap;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_lw(input int unsigned rd, input int unsigned rs1, input logic [11:0] imm);
        return {imm, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_sw(input int unsigned rs2, input int unsigned rs1, input logic [11:0] imm);
        return {imm[11:5], 5'(rs2), 5'(rs1), 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int unsigned rs2, input int unsigned rs1, input int unsigned rd);
        return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input int unsigned fwait, input int unsigned dwait,
                                input logic [31:0] ldata, input bit has_data, input logic we,
                                input logic [AW-1:0] daddr, input logic [31:0] wdata,
                                input logic [AW-1:0] pc, input int unsigned fgap);
        vec_t v;
        v.instr = instr; v.fwait = fwait; v.dwait = dwait; v.ldata = ldata;
        v.has_data = has_data; v.exp_we = we; v.exp_daddr = daddr; v.exp_wdata = wdata;
        v.exp_pc = pc; v.exp_fgap = fgap;
        return v;
    endfunction

    // Waits (bounded) for a request, holds Ack off for wait_n cycles, then acks with rdata.
    task automatic bus_cycle(input int unsigned wait_n, input logic [31:0] rdata,
                             output logic [AW-1:0] a, output logic w, output logic [31:0] wd,
                             output int unsigned gap);
        bit stable;
        stable = 1'b1;
        gap = 0;
        @(negedge Clk);
        while (Cs !== 1'b1 && gap < 20) begin
            gap++;
            @(negedge Clk);
        end
        a = Addr; w = We; wd = Wdata;
        if (Cs !== 1'b1) begin
            check("bus_request_timeout", {31'b0, Cs}, 32'd1);
            return;
        end
        for (int unsigned i = 0; i < wait_n; i++) begin
            @(negedge Clk);
            if (Cs !== 1'b1 || Addr !== a || We !== w || Wdata !== wd) stable = 1'b0;
        end
        if (wait_n > 0) check("hold_stable", {31'b0, stable}, 32'd1);
        Ack = 1'b1;
        Rdata = rdata;
        @(posedge Clk);
        #1;
        Ack = 1'b0;
        Rdata = '0;
    endtask

    task automatic apply_vec(input vec_t v);
        logic [AW-1:0] a;
        logic          w;
        logic [31:0]   wd;
        int unsigned   gap;
        bus_cycle(v.fwait, v.instr, a, w, wd, gap);
        check("fetch_addr", 32'(a), 32'(v.exp_pc));
        check("fetch_we", {31'b0, w}, 32'd0);
        check("fetch_gap", gap, v.exp_fgap);
        if (v.has_data) begin
            bus_cycle(v.dwait, v.ldata, a, w, wd, gap);
            check("data_gap", gap, 32'd1);
            check("data_addr", 32'(a), 32'(v.exp_daddr));
            check("data_we", {31'b0, w}, {31'b0, v.exp_we});
            if (v.exp_we) check("data_wdata", wd, v.exp_wdata);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t          tbl[$];
        logic [31:0]   sub_exp;
        logic [31:0]   m_reg [32];
        int unsigned   m_pc;
        int unsigned   prev_gap;
        int unsigned   gap;
        logic [AW-1:0] a;
        logic          w;
        logic [31:0]   wd;
        logic [31:0]   instr;
        logic [31:0]   r;
        logic [31:0]   ld;
        logic [31:0]   ea;
        logic [6:0]    op;
        logic [2:0]    f3;
        logic [6:0]    f7;
        int unsigned   rd, rs1, rs2, kind;
        logic [11:0]   imm;

        sub_exp = SUB_EN ? 32'hFFFFE001 : 32'h0;
        //            instr                              fw dw ldata         dat we addr     wdata          pc  gap
        tbl.push_back(mk(enc_lw(1, 0, 12'h07F),           5, 5, 32'hFFFFF000, 1, 0, 10'h07F, 32'h0,         0,  0));
        tbl.push_back(mk(enc_lw(2, 0, 12'h07E),           0, 0, 32'h00000FFF, 1, 0, 10'h07E, 32'h0,         1,  1));
        tbl.push_back(mk(enc_r(7'h00, 2, 1, 3),           0, 0, 32'h0,        0, 0, 10'h0,   32'h0,         2,  1));
        tbl.push_back(mk(enc_sw(3, 0, 12'h005),           0, 3, 32'h0,        1, 1, 10'h005, 32'hFFFFFFFF,  3,  1));
        tbl.push_back(mk(enc_sw(1, 0, 12'h008),           1, 0, 32'h0,        1, 1, 10'h008, 32'hFFFFF000,  4,  0));
        tbl.push_back(mk(enc_lw(0, 0, 12'h010),           0, 0, 32'h12345678, 1, 0, 10'h010, 32'h0,         5,  0));
        tbl.push_back(mk(enc_sw(0, 0, 12'h006),           0, 0, 32'h0,        1, 1, 10'h006, 32'h0,         6,  1));
        tbl.push_back(mk(32'h00500093,                    0, 0, 32'h0,        0, 0, 10'h0,   32'h0,         7,  0));
        tbl.push_back(mk(enc_r(7'h20, 2, 1, 4),           0, 0, 32'h0,        0, 0, 10'h0,   32'h0,         8,  1));
        tbl.push_back(mk(enc_sw(4, 0, 12'h007),           0, 0, 32'h0,        1, 1, 10'h007, sub_exp,       9,  1));
        tbl.push_back(mk(enc_r(7'h00, 3, 3, 5),           2, 0, 32'h0,        0, 0, 10'h0,   32'h0,         10, 0));
        tbl.push_back(mk(enc_sw(5, 3, 12'h001),           0, 0, 32'h0,        1, 1, 10'h000, 32'hFFFFFFFE,  11, 1));
        tbl.push_back(mk(enc_lw(6, 0, 12'hFFF),           0, 2, 32'hA5A5A5A5, 1, 0, 10'h3FF, 32'h0,         12, 0));
        tbl.push_back(mk(enc_sw(6, 1, 12'hFFE),           0, 0, 32'h0,        1, 1, 10'h3FE, 32'hA5A5A5A5,  13, 1));

        repeat (3) @(negedge Clk);
        check("reset_cs", {31'b0, Cs}, 32'd0);
        check("reset_we", {31'b0, We}, 32'd0);
        check("reset_addr", 32'(Addr), 32'd0);
        check("reset_wdata", Wdata, 32'd0);
        Rst = 1'b1;

        for (int unsigned i = 0; i < tbl.size(); i++) apply_vec(tbl[i]);

        // LW aborted by reset while its data access is pending.
        bus_cycle(0, enc_lw(7, 0, 12'h020), a, w, wd, gap);
        check("abort_fetch_addr", 32'(a), 32'd14);
        gap = 0;
        @(negedge Clk);
        while (Cs !== 1'b1 && gap < 20) begin
            gap++;
            @(negedge Clk);
        end
        check("abort_mem_addr", 32'(Addr), 32'h020);
        check("abort_mem_we", {31'b0, We}, 32'd0);
        repeat (2) @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        check("abort_cs", {31'b0, Cs}, 32'd0);
        check("abort_we", {31'b0, We}, 32'd0);
        check("abort_addr", 32'(Addr), 32'd0);
        check("abort_wdata", Wdata, 32'd0);
        @(posedge Clk);
        #1 check("abort_cs_held", {31'b0, Cs}, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        apply_vec(mk(enc_sw(7, 0, 12'h008), 0, 0, 32'h0, 1, 1, 10'h008, 32'h0, 0, 0));
        apply_vec(mk(enc_sw(1, 0, 12'h009), 0, 0, 32'h0, 1, 1, 10'h009, 32'h0, 1, 0));

        // Random programs against an instruction-level model.
        @(negedge Clk);
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        for (int unsigned i = 0; i < 32; i++) m_reg[i] = '0;
        m_pc = 0;
        prev_gap = 0;
        for (int unsigned n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 6);
            rd  = $urandom_range(0, 7);
            rs1 = $urandom_range(0, 7);
            rs2 = $urandom_range(0, 7);
            r   = $urandom;
            imm = r[11:0];
            case (kind)
                0:       instr = enc_lw(rd, rs1, imm);
                1:       instr = enc_sw(rs2, rs1, imm);
                2:       instr = enc_r(7'h00, rs2, rs1, rd);
                3:       instr = enc_r(7'h20, rs2, rs1, rd);
                4:       instr = {r[31:7], 7'b0010011};
                5:       instr = {imm, 5'(rs1), 3'b110, 5'(rd), 7'b0000011};
                default: instr = enc_r(7'h01, rs2, rs1, rd);
            endcase

            op = instr[6:0];
            f3 = instr[14:12];
            f7 = instr[31:25];
            bus_cycle($urandom_range(0, 3), instr, a, w, wd, gap);
            check("rnd_fetch_addr", 32'(a), m_pc);
            check("rnd_fetch_we", {31'b0, w}, 32'd0);
            check("rnd_fetch_gap", gap, prev_gap);
            prev_gap = 1;

            if (op == 7'b0000011 && f3 == 3'b010) begin
                ea = (m_reg[instr[19:15]] + {{20{instr[31]}}, instr[31:20]}) % RAM;
                ld = $urandom;
                bus_cycle($urandom_range(0, 3), ld, a, w, wd, gap);
                check("rnd_lw_addr", 32'(a), ea);
                check("rnd_lw_we", {31'b0, w}, 32'd0);
                if (instr[11:7] != 5'd0) m_reg[instr[11:7]] = ld;
            end else if (op == 7'b0100011 && f3 == 3'b010) begin
                ea = (m_reg[instr[19:15]] + {{20{instr[31]}}, instr[31:25], instr[11:7]}) % RAM;
                bus_cycle($urandom_range(0, 3), 32'h0, a, w, wd, gap);
                check("rnd_sw_addr", 32'(a), ea);
                check("rnd_sw_we", {31'b0, w}, 32'd1);
                check("rnd_sw_wdata", wd, m_reg[instr[24:20]]);
                prev_gap = 0;
            end else if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'h00) begin
                if (instr[11:7] != 5'd0) m_reg[instr[11:7]] = m_reg[instr[19:15]] + m_reg[instr[24:20]];
            end else if (SUB_EN && op == 7'b0110011 && f3 == 3'b000 && f7 == 7'h20) begin
                if (instr[11:7] != 5'd0) m_reg[instr[11:7]] = m_reg[instr[19:15]] - m_reg[instr[24:20]];
            end
            m_pc = (m_pc + 1) % RAM;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/risc_core.md
# risc_core

Multi-cycle RV32I-subset processor core (module `risc_core`) executing LW, SW and ADD (plus optional SUB) from a single shared, word-addressed memory bus with a request/acknowledge handshake. It sits between the system memory/bus fabric and nothing else: all instruction fetches and data accesses go through one port. Each instruction takes a fixed number of states, and every memory access stalls until `Ack`.

## Interface
- `RAM_CAPACITY`, default 1024: memory size in words; sets the `Addr` width to `$clog2(RAM_CAPACITY)`.
- `WORD_SIZE_B`, default 4: word size in bytes; the data width is `8*WORD_SIZE_B` (32).
- `Clk`  in  1: clock, rising edge.
- `Rst`  in  1: reset, asynchronous, active-low.
- `Addr`  out  `$clog2(RAM_CAPACITY)`: word address; PC during fetch, effective address during data access.
- `Cs`  out  1: access request; held until `Ack`.
- `We`  out  1: 1 = write, 0 = read; valid only while `Cs` = 1.
- `Wdata`  out  32: store data.
- `Rdata`  in  32: instruction or load data; valid in the `Ack` cycle.
- `Ack`  in  1: one-cycle completion pulse from memory.

## Operation
- Supported instructions, all other encodings are a NOP (PC+1, no register or memory effect):
  - LW: opcode 0000011, funct3 010.
  - SW: opcode 0100011, funct3 010.
  - ADD: opcode 0110011, funct3 000, funct7 0000000.
- Register file: 32×32; x0 reads 0 and ignores writes; all registers clear to 0 on reset.
- PC: word index, resets to 0, increments by 1 after each instruction; no branches.
- Effective address = `rs1 + sext(imm12)`, truncated to `Addr` width; wraps modulo `RAM_CAPACITY`.
  - LW immediate: `[31:20]`.
  - SW immediate: `{[31:25],[11:7]}`.
- ADD: `rd = rs1 + rs2` mod 2^32, carry and overflow ignored.
- FSM states:
  - FETCH: `Cs`=1, `We`=0, `Addr`=PC. On `Ack`, latch `Rdata` into IR, then go to EXEC.
  - EXEC: `Cs`=0.
    - ADD/SUB: write rd, PC+1, go to FETCH.
    - LW/SW: go to MEM.
    - Otherwise: PC+1, go to FETCH.
  - MEM: `Cs`=1, `Addr`=effective address.
    - SW: `We`=1, `Wdata`=rs2.
    - LW: `We`=0.
    - On `Ack`: LW latches `Rdata` and goes to WB; SW does PC+1 and goes to FETCH.
  - WB: `Cs`=0; write rd with the loaded data, PC+1, go to FETCH.
- `Ack` outside FETCH/MEM is ignored. While waiting, `Addr`/`We`/`Wdata` stay stable.

## Timing
- Reset:
  - While `Rst`=0: `Cs`=0, `We`=0, `Addr`=0, `Wdata`=0; state = FETCH.
  - Reset asserted mid-operation aborts immediately; no partial register write.
- `Cs` rises in the first cycle after `Rst` deasserts.
- `Ack` may arrive in the first cycle of `Cs`; memory latency is unbounded.
- Instruction latency with zero-wait memory:
  - ADD: 2 cycles (FETCH, EXEC).
  - SW: 3 cycles (FETCH, EXEC, MEM).
  - LW: 4 cycles (FETCH, EXEC, MEM, WB).
- The next FETCH `Cs` is asserted in the cycle after EXEC, MEM(SW) or WB.
- A register written in EXEC or WB is readable by the next instruction's EXEC.

## Configuration
- `RISC_CORE_SUB_EN` defined: opcode 0110011, funct3 000, funct7 0100000 executes SUB, `rd = rs1 - rs2` mod 2^32.
- `RISC_CORE_SUB_EN` not defined: that encoding is a NOP.

## Structure
- Package `risc_core_pkg`:
  - Opcode constants (LW, SW, OP).
  - funct3/funct7 constants.
  - FSM state enum (FETCH, EXEC, MEM, WB).
  - `WORD_SIZE_B` default.
- Sub-module `risc_core_regfile`: 2 read ports, 1 write port, x0 hardwired to 0, async active-low clear.

## Test plan
- LW x1 from x0+0x07F:
  - Stimulus: instruction acked at fetch `Addr` 0; data 0xFFFFF000 acked at `Addr` 0x07F with `We`=0.
  - Response: x1 = 0xFFFFF000, next fetch at `Addr` 1.
- LW x2 from x0+0x07E, then ADD x3, x1, x2:
  - Stimulus: load data 0x00000FFF.
  - Response: x3 = 0xFFFFFFFF; ADD fetched at `Addr` 2.
- SW x3 to x0+5:
  - Response: `Cs`=1, `We`=1, `Addr`=5, `Wdata`=0xFFFFFFFF held until `Ack`.
- Wait states:
  - Stimulus: `Ack` withheld for 5 cycles during fetch and during LW MEM.
  - Response: outputs stable, no PC or register change until `Ack`.
- LW to x0, and an unsupported opcode:
  - Response: x0 stays 0; unsupported opcode advances PC by 1 with no `Cs` data access.
- `Rst` low during LW MEM:
  - Response: outputs go to 0 immediately; after release, fetch from `Addr` 0 and rd is unchanged (0).
